// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings, instruction opcodes and the decoded control bundle.
// Latency: none (declarations only).
// Backpressure: not applicable.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_AND = 2'b00,
        ALU_OR  = 2'b01,
        ALU_ADD = 2'b10,
        ALU_SUB = 2'b11
    } alu_op_e;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    // Control travelling with an instruction into execute.
    typedef struct packed {
        alu_op_e alu_op;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    illegal;
    } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational decode of opcode/funct fields into ALU op and pipeline control.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing stage decides when the result is captured.
module alu_decoder
    import alu_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    input  logic [4:0] rd_i,
    output ctrl_t      ctrl_o,
    output logic       use_imm_o
);

    logic legal;

    // Classify the instruction; anything unrecognised stays illegal with ADD and no side effects.
    always_comb begin
        ctrl_o           = '0;
        ctrl_o.alu_op    = ALU_ADD;
        use_imm_o        = 1'b0;
        legal            = 1'b0;
        unique case (opcode_i)
            OPC_R: begin
                unique case (funct3_i)
                    3'b000: begin
                        if (funct7_i == F7_ADD) begin
                            ctrl_o.alu_op = ALU_ADD;
                            legal         = 1'b1;
                        end else if (funct7_i == F7_SUB) begin
                            ctrl_o.alu_op = ALU_SUB;
                            legal         = 1'b1;
                        end
                    end
                    3'b111: begin
                        ctrl_o.alu_op = ALU_AND;
                        legal         = 1'b1;
                    end
                    3'b110: begin
                        ctrl_o.alu_op = ALU_OR;
                        legal         = 1'b1;
                    end
                    default: ;
                endcase
                ctrl_o.reg_write = legal;
            end
            OPC_I: begin
                unique case (funct3_i)
                    3'b000: begin
                        ctrl_o.alu_op = ALU_ADD;
                        legal         = 1'b1;
                    end
                    3'b111: begin
                        ctrl_o.alu_op = ALU_AND;
                        legal         = 1'b1;
                    end
                    3'b110: begin
                        ctrl_o.alu_op = ALU_OR;
                        legal         = 1'b1;
                    end
                    default: ;
                endcase
                use_imm_o        = legal;
                ctrl_o.reg_write = legal;
            end
            OPC_LOAD: begin
                legal            = 1'b1;
                use_imm_o        = 1'b1;
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            OPC_STORE: begin
                legal            = 1'b1;
                use_imm_o        = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            default: ;
        endcase
        if (!legal) begin
            ctrl_o.alu_op    = ALU_ADD;
            ctrl_o.reg_write = 1'b0;
            ctrl_o.mem_read  = 1'b0;
            ctrl_o.mem_write = 1'b0;
        end
        ctrl_o.illegal = !legal;
        // Writes to x0 are architecturally discarded, so never request them.
        if (rd_i == 5'd0) begin
            ctrl_o.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode/execute pipeline register: one-entry skid-free stage with flush and issue counter.
// Latency: 1 cycle from accepted valid_i to valid_o.
// Backpressure: ready_o = !valid_o || ready_i; outputs hold while valid_o && !ready_i.
module id_ex_stage
    import alu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        flush_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic [31:0] imm_i,
    input  logic [4:0]  rd_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [1:0]  alu_op_o,
    output logic [4:0]  rd_o,
    output logic        reg_write_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        illegal_o,
    output logic [15:0] issue_cnt_o
);

    ctrl_t       dec_ctrl;
    logic        dec_use_imm;
    ctrl_t       ctrl_q;
    logic        valid_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [4:0]  rd_q;
    logic [15:0] cnt_q;
    logic        cap;
    logic        xfer;

    alu_decoder u_dec (
        .opcode_i  (opcode_i),
        .funct3_i  (funct3_i),
        .funct7_i  (funct7_i),
        .rd_i      (rd_i),
        .ctrl_o    (dec_ctrl),
        .use_imm_o (dec_use_imm)
    );

    assign ready_o = !valid_q || ready_i;
    assign cap     = valid_i && ready_o && !flush_i;
    assign xfer    = valid_q && ready_i && !flush_i;

    // Valid bit: flush wins, then capture (covers back-to-back), then drain on transfer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (cap) begin
            valid_q <= 1'b1;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    // Payload registers load only on capture, so they stay frozen during a stall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q    <= '0;
            b_q    <= '0;
            rd_q   <= '0;
            ctrl_q <= '0;
        end else if (cap) begin
            a_q    <= rs1_data_i;
            b_q    <= dec_use_imm ? imm_i : rs2_data_i;
            rd_q   <= rd_i;
            ctrl_q <= dec_ctrl;
        end
    end

    // Count completed downstream handshakes; natural 16-bit wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (xfer) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign valid_o     = valid_q;
    assign a_o         = a_q;
    assign b_o         = b_q;
    assign alu_op_o    = ctrl_q.alu_op;
    assign rd_o        = rd_q;
    assign reg_write_o = ctrl_q.reg_write;
    assign mem_read_o  = ctrl_q.mem_read;
    assign mem_write_o = ctrl_q.mem_write;
    assign illegal_o   = ctrl_q.illegal;
    assign issue_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, handshake, flush, counter wrap and async reset.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: ready_i driven directly by the stimulus sequence.
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic        flush_i;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [31:0] imm_i;
    logic [4:0]  rd_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] a_o;
    logic [31:0] b_o;
    logic [1:0]  alu_op_o;
    logic [4:0]  rd_o;
    logic        reg_write_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic        illegal_o;
    logic [15:0] issue_cnt_o;

    int checks   = 0;
    int failures = 0;

    id_ex_stage dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .flush_i     (flush_i),
        .opcode_i    (opcode_i),
        .funct3_i    (funct3_i),
        .funct7_i    (funct7_i),
        .rs1_data_i  (rs1_data_i),
        .rs2_data_i  (rs2_data_i),
        .imm_i       (imm_i),
        .rd_i        (rd_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .a_o         (a_o),
        .b_o         (b_o),
        .alu_op_o    (alu_op_o),
        .rd_o        (rd_o),
        .reg_write_o (reg_write_o),
        .mem_read_o  (mem_read_o),
        .mem_write_o (mem_write_o),
        .illegal_o   (illegal_o),
        .issue_cnt_o (issue_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] im, input logic [4:0] rd);
        valid_i    = v;
        opcode_i   = op;
        funct3_i   = f3;
        funct7_i   = f7;
        rs1_data_i = r1;
        rs2_data_i = r2;
        imm_i      = im;
        rd_i       = rd;
    endtask

    initial begin
        rst_ni  = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b0;
        drive(1'b0, 7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        #1;
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_cnt", {16'd0, issue_cnt_o}, 32'd0);
        step();
        step();
        rst_ni = 1'b1;

        // R-type SUB
        drive(1'b1, 7'b0110011, 3'b000, 7'b0100000, 32'd5, 32'd3, 32'd0, 5'd1);
        step();
        check("sub_valid", {31'd0, valid_o}, 32'd1);
        check("sub_op", {30'd0, alu_op_o}, 32'd3);
        check("sub_a", a_o, 32'd5);
        check("sub_b", b_o, 32'd3);
        check("sub_rw", {31'd0, reg_write_o}, 32'd1);
        check("sub_rd", {27'd0, rd_o}, 32'd1);
        valid_i = 1'b0;
        ready_i = 1'b1;
        step();
        check("sub_drain_valid", {31'd0, valid_o}, 32'd0);
        check("sub_drain_cnt", {16'd0, issue_cnt_o}, 32'd1);

        // addi to x0
        ready_i = 1'b0;
        drive(1'b1, 7'b0010011, 3'b000, 7'd0, 32'h10, 32'h55, 32'hFFFF_FFFF, 5'd0);
        step();
        check("addi_op", {30'd0, alu_op_o}, 32'd2);
        check("addi_a", a_o, 32'h10);
        check("addi_b", b_o, 32'hFFFF_FFFF);
        check("addi_rw", {31'd0, reg_write_o}, 32'd0);
        valid_i = 1'b0;
        ready_i = 1'b1;
        step();
        check("addi_cnt", {16'd0, issue_cnt_o}, 32'd2);

        // Store, then stall 3 cycles with changing inputs
        ready_i = 1'b0;
        drive(1'b1, 7'b0100011, 3'b010, 7'd0, 32'h100, 32'hAB, 32'd8, 5'd5);
        step();
        check("st_valid", {31'd0, valid_o}, 32'd1);
        check("st_mw", {31'd0, mem_write_o}, 32'd1);
        check("st_rw", {31'd0, reg_write_o}, 32'd0);
        check("st_op", {30'd0, alu_op_o}, 32'd2);
        check("st_b", b_o, 32'd8);
        drive(1'b1, 7'b0110011, 3'b111, 7'd0, 32'h777, 32'h999, 32'h1, 5'd9);
        for (int i = 0; i < 3; i++) begin
            check("stall_ready", {31'd0, ready_o}, 32'd0);
            step();
            check("stall_valid", {31'd0, valid_o}, 32'd1);
            check("stall_a", a_o, 32'h100);
            check("stall_b", b_o, 32'd8);
            check("stall_mw", {31'd0, mem_write_o}, 32'd1);
            check("stall_rd", {27'd0, rd_o}, 32'd5);
            check("stall_cnt", {16'd0, issue_cnt_o}, 32'd2);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        step();
        check("st_cnt", {16'd0, issue_cnt_o}, 32'd3);
        check("st_drain_valid", {31'd0, valid_o}, 32'd0);

        // valid_i with flush_i on an empty stage
        drive(1'b1, 7'b0110011, 3'b000, 7'd0, 32'd1, 32'd2, 32'd0, 5'd3);
        flush_i = 1'b1;
        step();
        check("flush_in_valid", {31'd0, valid_o}, 32'd0);
        check("flush_in_cnt", {16'd0, issue_cnt_o}, 32'd3);

        // Load held, then flushed while ready_i=1
        flush_i = 1'b0;
        ready_i = 1'b0;
        drive(1'b1, 7'b0000011, 3'b010, 7'd0, 32'd20, 32'd0, 32'd4, 5'd7);
        step();
        check("ld_mr", {31'd0, mem_read_o}, 32'd1);
        check("ld_rw", {31'd0, reg_write_o}, 32'd1);
        check("ld_b", b_o, 32'd4);
        flush_i = 1'b1;
        ready_i = 1'b1;
        step();
        check("flush_held_valid", {31'd0, valid_o}, 32'd0);
        check("flush_held_cnt", {16'd0, issue_cnt_o}, 32'd3);
        flush_i = 1'b0;

        // Illegal opcode still passes
        ready_i = 1'b0;
        drive(1'b1, 7'b1111111, 3'b000, 7'd0, 32'd1, 32'd2, 32'd3, 5'd3);
        step();
        check("ill_valid", {31'd0, valid_o}, 32'd1);
        check("ill_flag", {31'd0, illegal_o}, 32'd1);
        check("ill_rw", {31'd0, reg_write_o}, 32'd0);
        check("ill_mw", {31'd0, mem_write_o}, 32'd0);
        check("ill_op", {30'd0, alu_op_o}, 32'd2);

        // Back-to-back: R-type AND replaces illegal while it transfers
        ready_i = 1'b1;
        drive(1'b1, 7'b0110011, 3'b111, 7'd0, 32'hF0, 32'h3C, 32'd0, 5'd2);
        step();
        check("b2b_valid", {31'd0, valid_o}, 32'd1);
        check("b2b_op", {30'd0, alu_op_o}, 32'd0);
        check("b2b_ill", {31'd0, illegal_o}, 32'd0);
        check("b2b_b", b_o, 32'h3C);
        check("b2b_cnt", {16'd0, issue_cnt_o}, 32'd4);
        drive(1'b1, 7'b0010011, 3'b110, 7'd0, 32'hF0, 32'h3C, 32'h0F, 5'd4);
        step();
        check("ori_op", {30'd0, alu_op_o}, 32'd1);
        check("ori_b", b_o, 32'h0F);
        check("ori_cnt", {16'd0, issue_cnt_o}, 32'd5);

        // Stream until the counter reaches 0xFFFF, then wrap
        for (int i = 0; i < 70000 && issue_cnt_o != 16'hFFFF; i++) begin
            step();
        end
        check("cnt_reach_ffff", {16'd0, issue_cnt_o}, 32'h0000_FFFF);
        check("cnt_ffff_valid", {31'd0, valid_o}, 32'd1);
        step();
        check("cnt_wrap", {16'd0, issue_cnt_o}, 32'd0);
        step();
        check("cnt_after_wrap", {16'd0, issue_cnt_o}, 32'd1);

        // Stall, then reset asynchronously mid-cycle
        ready_i = 1'b0;
        step();
        check("pre_rst_valid", {31'd0, valid_o}, 32'd1);
        check("pre_rst_ready", {31'd0, ready_o}, 32'd0);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_valid", {31'd0, valid_o}, 32'd0);
        check("arst_a", a_o, 32'd0);
        check("arst_b", b_o, 32'd0);
        check("arst_op", {30'd0, alu_op_o}, 32'd0);
        check("arst_rd", {27'd0, rd_o}, 32'd0);
        check("arst_ctl", {28'd0, reg_write_o, mem_read_o, mem_write_o, illegal_o}, 32'd0);
        check("arst_cnt", {16'd0, issue_cnt_o}, 32'd0);
        check("arst_ready", {31'd0, ready_o}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports clk_i in 1: single clock; all state on rising edge.
REQ-002 SHALL have port rst_ni in 1: reset, asynchronous, active-low.
REQ-003 SHALL have ports valid_i in 1 and ready_o out 1: upstream decode handshake.
REQ-004 SHALL have port flush_i in 1: kill held and incoming instruction (branch/trap).
REQ-005 SHALL have ports opcode_i in 7, funct3_i in 3 and funct7_i in 7: instruction fields.
REQ-006 SHALL have ports rs1_data_i in 32, rs2_data_i in 32, imm_i in 32 and rd_i in 5: operands, immediate and destination.
REQ-007 SHALL have ports valid_o out 1 and ready_i in 1: downstream execute handshake.
REQ-008 SHALL have ports a_o out 32, b_o out 32 and alu_op_o out 2: operands and opcode for ALU inputs a_i, b_i and AluOp_i.
REQ-009 SHALL have ports rd_o out 5, reg_write_o out 1, mem_read_o out 1, mem_write_o out 1 and illegal_o out 1: control passed downstream.
REQ-010 SHALL have port issue_cnt_o out 16: count of instructions handed downstream.

Function
REQ-011 SHALL hold one instruction; ready_o = !valid_o || ready_i (combinational).
REQ-012 SHALL capture inputs when valid_i && ready_o && !flush_i; valid_o goes 1 next cycle (latency 1).
REQ-013 SHALL clear valid_o when ready_i && valid_o and no new capture occurs.
REQ-014 SHALL keep all outputs stable while valid_o && !ready_i (stall).
REQ-015 SHALL clear valid_o next cycle on flush_i, overriding capture and hold; payload registers may keep stale values.
REQ-016 SHALL decode R-type (0110011): funct3 000/funct7 0000000 -> ADD; 000/0100000 -> SUB; 111 -> AND; 110 -> OR; b_o = rs2; reg_write=1.
REQ-017 SHALL decode I-type ALU (0010011): funct3 000 -> ADD, 111 -> AND, 110 -> OR; b_o = imm; reg_write=1.
REQ-018 SHALL decode load (0000011) as ADD, b_o = imm, mem_read=1, reg_write=1.
REQ-019 SHALL decode store (0100011) as ADD, b_o = imm, mem_write=1, reg_write=0.
REQ-020 SHALL decode any other encoding as illegal_o=1, alu_op=ADD, reg_write=mem_read=mem_write=0; the instruction still passes with valid_o=1.
REQ-021 SHALL force reg_write_o=0 when rd_i=0.
REQ-022 SHALL always set a_o = rs1_data_i.
REQ-023 SHALL increment issue_cnt_o on each cycle valid_o && ready_i && !flush_i, wrapping 0xFFFF -> 0x0000.
REQ-024 SHALL treat simultaneous downstream transfer and upstream capture as back-to-back: new instruction held, counter increments, no bubble.

Reset
REQ-025 SHALL on rst_ni=0 immediately clear valid_o, a_o, b_o, alu_op_o (00), rd_o, reg_write_o, mem_read_o, mem_write_o, illegal_o and issue_cnt_o.
REQ-026 SHALL drop an instruction in flight at reset with no output handshake; ready_o=1 during reset.

Structure
REQ-027 SHALL take ALU opcode constants (AND=00, OR=01, ADD=10, SUB=11) and opcode constants (R, I, LOAD, STORE) from shared package alu_pkg.
REQ-028 SHALL place decode in combinational sub-module alu_decoder; id_ex_stage holds the registers, handshake and counter.

Verification
REQ-029 SHALL check: R-type 0110011/000/0100000, rs1=5, rs2=3, rd=1 -> next cycle valid_o=1, alu_op=11, a=5, b=3, reg_write=1.
REQ-030 SHALL check: addi rs1=0x10, imm=0xFFFFFFFF, rd=0 -> alu_op=10, b=0xFFFFFFFF, reg_write=0.
REQ-031 SHALL check: store held with ready_i=0 for 3 cycles -> outputs stable, ready_o=0; ready_i=1 -> issue_cnt_o +1.
REQ-032 SHALL check: valid_i and flush_i both 1 -> valid_o=0 next cycle, count unchanged.
REQ-033 SHALL check: opcode 1111111 -> illegal_o=1, reg_write=0, mem_write=0.
REQ-034 SHALL check: preload count 0xFFFF, one transfer -> issue_cnt_o=0x0000; assert rst_ni mid-stall -> all outputs 0 without a clock edge.
